mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported, handshaked unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the pipelined MIPS core. It runs one transaction at a time and picks between requesters round-robin. It holds stall outputs high so the pipeline can freeze while a requester waits. Sits between the IF/MEM stage logic and the external memory model; replaces the separate instruction ROM and data memory when the core is built with a unified memory.

Parameters:
AW, 32, address width for both ports and memory.
DW, 32, data width.
TIMEOUT_CYCLES, 255, maximum mem_req cycles without mem_ack before abort (only with MEMARB_TIMEOUT_EN).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
i_req  input  1  fetch request; held with i_addr stable until i_ack.
i_addr  input  AW  fetch address.
i_ack  output  1  one-cycle pulse; i_rdata valid this cycle.
i_rdata  output  DW  fetched word, registered.
i_err  output  1  pulses with i_ack on timeout abort.
stall_if  output  1  i_req & ~i_ack (combinational).
d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_ack.
d_we  input  1  1 = store, 0 = load.
d_addr  input  AW  data address.
d_wdata  input  DW  store data.
d_ack  output  1  one-cycle pulse; d_rdata valid for loads.
d_rdata  output  DW  load data, registered.
d_err  output  1  pulses with d_ack on timeout abort.
stall_mem  output  1  d_req & ~d_ack (combinational).
mem_req  output  1  registered; held until mem_ack.
mem_we  output  1  registered write enable.
mem_addr  output  AW  registered address.
mem_wdata  output  DW  registered write data.
mem_rdata  input  DW  valid when mem_ack=1.
mem_ack  input  1  completion, may assert in the first mem_req cycle.

Behaviour:
- Reset, asynchronous: state=IDLE. mem_req, mem_we, i_ack, d_ack, i_err, d_err all 0. mem_addr, mem_wdata, i_rdata, d_rdata all 0. last_grant=I, so D wins the first tie.
- States: IDLE, IBUSY, DBUSY, RESP.
- IDLE, only d_req: latch d_we/d_addr/d_wdata into mem_* and set mem_req=1. Set owner=D, last_grant=D. Next state DBUSY.
- IDLE, only i_req: latch i_addr, set mem_we=0, mem_req=1, owner=I, last_grant=I. Next state IBUSY.
- IDLE, both requests: grant the port that is not last_grant.
- IDLE, no request: stay in IDLE.
- IBUSY/DBUSY, mem_ack=1: clear mem_req and mem_we. Capture mem_rdata into the owner's rdata register. For a store, d_rdata is loaded with 0. Next state RESP.
- IBUSY/DBUSY, mem_ack=0: hold all mem_* outputs.
- RESP: owner's x_ack=1 for exactly one cycle. Next state IDLE unconditionally, so a requester still holding req in the ack cycle is not re-granted.
- Requester rule: in the cycle after x_ack, the requester either drops req or presents a new request.
- Latency: req seen in cycle 0, mem_req in cycles 1..N, mem_ack in cycle N, x_ack in cycle N+1. Minimum 3 cycles per transaction, back-to-back.
- Non-owner rdata registers hold their previous value.
- mem_ack in IDLE or RESP is ignored.
- Reset asserted mid-transaction: mem_req drops immediately and the transaction is abandoned with no ack. The memory must tolerate mem_req deasserting without an ack.

Optional Feature:
MEMARB_TIMEOUT_EN.
- Defined: a counter clears on entry to IBUSY/DBUSY and increments each cycle without mem_ack. When it reaches TIMEOUT_CYCLES, the arbiter drops mem_req, loads the owner's rdata with 0, and goes to RESP. In RESP, x_err=1 together with x_ack.
- Undefined: the arbiter waits forever, no counter is built, and i_err/d_err are tied to 0.

Test Plan:
- Single fetch: i_req=1, i_addr=0x40, mem_ack one cycle after mem_req with mem_rdata=0x8C010004 -> mem_addr=0x40, mem_we=0; i_ack 1 cycle with i_rdata=0x8C010004; stall_if high until i_ack.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, immediate mem_ack -> mem_we=1, mem_wdata=0xDEADBEEF; d_ack in 3rd cycle after request; d_rdata=0.
- Contention: i_req and d_req both high from reset, memory acks immediately -> grant order D, I, D, I; each ack 3 cycles apart; stall_if/stall_mem track correctly.
- Slow memory: mem_ack delayed 5 cycles -> mem_req/mem_addr stable for 5 cycles; the other port is not granted meanwhile.
- Reset mid-DBUSY -> mem_req goes 0 without waiting for clk; no d_ack; after release, a held d_req is re-issued.
- With MEMARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no mem_ack -> mem_req deasserts after 4 cycles; i_ack=1 and i_err=1 in the same cycle; i_rdata=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one handshaked memory between IF fetch and MEM load/store.
// Define MEMARB_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES unacknowledged mem_req cycles.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  output logic          stall_if,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          stall_mem,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;
  state_t state_q;
  logic last_d_q, mem_req_q, mem_we_q, i_ack_q, d_ack_q, i_err_q, d_err_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, i_rdata_q, d_rdata_q, rdata_d;
  logic grant_d, busy, done, abort;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  // On a tie the data port wins unless it was the last one served.
  assign grant_d = d_req & ~(i_req & last_d_q);
  assign busy = (state_q == IBUSY) | (state_q == DBUSY);
  assign done = busy & (mem_ack | abort);
  assign rdata_d = (abort | mem_we_q) ? '0 : mem_rdata;
`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign abort = ~mem_ack & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= (busy & ~done) ? cnt_q + 1'b1 : '0;
  end
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
      case (state_q)
        IDLE: if (i_req | d_req) begin
          state_q    <= grant_d ? DBUSY : IBUSY;
          last_d_q   <= grant_d;
          mem_req_q  <= 1'b1;
          mem_we_q   <= grant_d & d_we;
          mem_addr_q <= grant_d ? d_addr : i_addr;
          if (grant_d) mem_wdata_q <= d_wdata;
        end
        IBUSY, DBUSY: if (done) begin
          state_q   <= RESP;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          if (state_q == DBUSY) begin
            d_rdata_q <= rdata_d;
            d_ack_q   <= 1'b1;
            d_err_q   <= abort;
          end else begin
            i_rdata_q <= rdata_d;
            i_ack_q   <= 1'b1;
            i_err_q   <= abort;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = i_req & ~i_ack_q;
  assign stall_mem = d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset, i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic i_ack, i_err, stall_if, d_ack, d_err, stall_mem, mem_req, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .d_err(d_err), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick;
    checks++;
    if ({mem_req, mem_we, i_ack, d_ack, i_err, d_err, stall_if, stall_mem} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {mem_req, mem_we, i_ack, d_ack, i_err, d_err, stall_if, stall_mem});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got i=%h d=%h expected 0 0", i_rdata, d_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    i_req = 1'b1; i_addr = 32'h40;
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL fetch_issue: got req=%b addr=%h we=%b expected 1 00000040 0", mem_req, mem_addr, mem_we);
    end
    checks++;
    if (stall_if !== 1'b1 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall: got stall_if=%b i_ack=%b expected 1 0", stall_if, i_ack);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL fetch_hold: got req=%b addr=%h expected 1 00000040", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h8C010004;
    tick;
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h8C010004 || mem_req !== 1'b0 || i_err !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack: got ack=%b rdata=%h req=%b err=%b expected 1 8c010004 0 0", i_ack, i_rdata, mem_req, i_err);
    end
    checks++;
    if (stall_if !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall_release: got %b expected 0", stall_if);
    end
    i_req = 1'b0;
    tick;
    checks++;
    if (i_ack !== 1'b0 || i_rdata !== 32'h8C010004) begin
      errors++;
      $display("FAIL fetch_after: got ack=%b rdata=%h expected 0 8c010004", i_ack, i_rdata);
    end
  endtask

  task automatic test_slow_memory;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int c = 1; c <= 5; c++) begin
      tick;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL slow_hold c=%0d: got req=%b addr=%h we=%b expected 1 00000200 0", c, mem_req, mem_addr, mem_we);
      end
      checks++;
      if (i_ack !== 1'b0 || d_ack !== 1'b0 || stall_mem !== 1'b1 || (c > 1 && stall_if !== 1'b1)) begin
        errors++;
        $display("FAIL slow_wait c=%0d: got i_ack=%b d_ack=%b stall_mem=%b stall_if=%b expected 0 0 1 1", c, i_ack, d_ack, stall_mem, stall_if);
      end
      if (c == 1) begin i_req = 1'b1; i_addr = 32'h300; end
      mem_ack = (c == 5);
      mem_rdata = (c == 5) ? 32'hCAFE0200 : 32'hBAD0BAD0;
    end
    tick;
    mem_ack = 1'b0;
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE0200 || i_ack !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL slow_ack: got d_ack=%b d_rdata=%h i_ack=%b req=%b expected 1 cafe0200 0 0", d_ack, d_rdata, i_ack, mem_req);
    end
    d_req = 1'b0;
    tick;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL slow_resp_gap: got req=%b expected 0", mem_req);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL slow_next_grant: got req=%b addr=%h we=%b expected 1 00000300 0", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick;
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h11112222 || d_rdata !== 32'hCAFE0200) begin
      errors++;
      $display("FAIL slow_i_ack: got ack=%b i_rdata=%h d_rdata=%h expected 1 11112222 cafe0200", i_ack, i_rdata, d_rdata);
    end
    i_req = 1'b0; mem_ack = 1'b0;
    tick;
  endtask

  task automatic test_store;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000100 deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== '0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL store_ack: got ack=%b rdata=%h req=%b we=%b expected 1 0 0 0", d_ack, d_rdata, mem_req, mem_we);
    end
    checks++;
    if (i_rdata !== 32'h11112222 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL store_other_port: got i_rdata=%h i_ack=%b expected 11112222 0", i_rdata, i_ack);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick;
    checks++;
    if (d_ack !== 1'b0) begin
      errors++;
      $display("FAIL store_pulse: got d_ack=%b expected 0", d_ack);
    end
  endtask

  task automatic test_timeout;
    i_req = 1'b1; i_addr = 32'h500; mem_ack = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      tick;
      checks++;
      if (mem_req !== 1'b1 || i_ack !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait c=%0d: got req=%b ack=%b expected 1 0", c, mem_req, i_ack);
      end
    end
    tick;
    checks++;
    if (mem_req !== 1'b0 || i_ack !== 1'b1 || i_err !== 1'b1 || i_rdata !== '0) begin
      errors++;
      $display("FAIL timeout_abort: got req=%b ack=%b err=%b rdata=%h expected 0 1 1 0", mem_req, i_ack, i_err, i_rdata);
    end
    i_req = 1'b0;
    tick;
    checks++;
    if (i_err !== 1'b0 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b ack=%b expected 0 0", i_err, i_ack);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      tick;
      checks++;
      if (mem_req !== 1'b1 || i_ack !== 1'b0 || i_err !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout_wait c=%0d: got req=%b ack=%b err=%b expected 1 0 0", c, mem_req, i_ack, i_err);
      end
    end
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (i_ack !== 1'b1 || i_err !== 1'b0 || i_rdata !== 32'h77) begin
      errors++;
      $display("FAIL no_timeout_ack: got ack=%b err=%b rdata=%h expected 1 0 00000077", i_ack, i_err, i_rdata);
    end
    i_req = 1'b0;
    tick;
`endif
  endtask

  task automatic test_contention;
    do_reset;
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int c = 1; c <= 12; c++) begin
      bit ei, ed;
      tick;
      ed = (c == 2 || c == 8);
      ei = (c == 5 || c == 11);
      checks++;
      if (i_ack !== ei || d_ack !== ed) begin
        errors++;
        $display("FAIL contention_ack c=%0d: got i=%b d=%b expected %b %b", c, i_ack, d_ack, ei, ed);
      end
      checks++;
      if (stall_if !== !ei || stall_mem !== !ed) begin
        errors++;
        $display("FAIL contention_stall c=%0d: got if=%b mem=%b expected %b %b", c, stall_if, stall_mem, !ei, !ed);
      end
      if (ei || ed) begin
        checks++;
        if ((ei ? i_rdata : d_rdata) !== 32'(c - 1)) begin
          errors++;
          $display("FAIL contention_data c=%0d: got %h expected %h", c, ei ? i_rdata : d_rdata, 32'(c - 1));
        end
      end
      if (c % 3 == 1) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== ((c == 1 || c == 7) ? 32'h2000 : 32'h1000)) begin
          errors++;
          $display("FAIL contention_grant c=%0d: got req=%b addr=%h", c, mem_req, mem_addr);
        end
      end
      mem_ack = mem_req;
      mem_rdata = 32'(c);
    end
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h55;
    tick;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rmid_issue: got req=%b expected 1", mem_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got req=%b ack=%b expected 0 0", mem_req, d_ack);
    end
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL rmid_held: got req=%b ack=%b expected 0 0", mem_req, d_ack);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b1 || mem_wdata !== 32'h55) begin
      errors++;
      $display("FAIL rmid_reissue: got req=%b addr=%h we=%b wdata=%h expected 1 00000400 1 00000055", mem_req, mem_addr, mem_we, mem_wdata);
    end
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (d_ack !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ack: got %b expected 1", d_ack);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick;
  endtask

  task automatic test_random;
    bit free_prev, ack_obs_prev, ack_given_prev, ack_given, busy, last_d, own_d, win_d, exp_i, exp_d, exp_we, cur_idle;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_data;
    int wait_cnt, delay;
    do_reset;
    free_prev = 1; ack_obs_prev = 0; ack_given_prev = 0; busy = 0; last_d = 0; own_d = 0;
    exp_we = 0; exp_addr = '0; exp_data = '0; wait_cnt = 0; delay = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick;
      exp_i = ack_given_prev && !own_d;
      exp_d = ack_given_prev && own_d;
      checks++;
      if (i_ack !== exp_i || d_ack !== exp_d) begin
        errors++;
        $display("FAIL rand_ack cyc=%0d: got i=%b d=%b expected %b %b", cyc, i_ack, d_ack, exp_i, exp_d);
      end
      if (exp_i || exp_d) begin
        checks++;
        if ((exp_i ? i_rdata : d_rdata) !== exp_data) begin
          errors++;
          $display("FAIL rand_rdata cyc=%0d: got %h expected %h", cyc, exp_i ? i_rdata : d_rdata, exp_data);
        end
      end
      checks++;
      if (stall_if !== (i_req && !exp_i) || stall_mem !== (d_req && !exp_d)) begin
        errors++;
        $display("FAIL rand_stall cyc=%0d: got if=%b mem=%b", cyc, stall_if, stall_mem);
      end
      if (free_prev && (i_req || d_req)) begin
        win_d = (i_req && d_req) ? !last_d : d_req;
        exp_addr = win_d ? d_addr : i_addr;
        exp_we = win_d && d_we;
        exp_wd = d_wdata;
        own_d = win_d; last_d = win_d; busy = 1; wait_cnt = 0;
        if (win_d) begin
          checks++;
          if (mem_wdata !== exp_wd) begin
            errors++;
            $display("FAIL rand_wdata cyc=%0d: got %h expected %h", cyc, mem_wdata, exp_wd);
          end
        end
      end
      cur_idle = (free_prev && !(i_req || d_req)) || ack_obs_prev;
      checks++;
      if (busy ? (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we) : (mem_req !== 1'b0 || mem_we !== 1'b0)) begin
        errors++;
        $display("FAIL rand_bus cyc=%0d: got req=%b addr=%h we=%b expected %b %h %b", cyc, mem_req, mem_addr, mem_we, busy, exp_addr, busy && exp_we);
      end
      ack_given = 0;
      if (busy && wait_cnt == delay) begin
        ack_given = 1; busy = 0; mem_ack = 1'b1;
        exp_data = exp_we ? '0 : DW'($urandom);
        mem_rdata = exp_we ? DW'($urandom) : exp_data;
        delay = $urandom_range(0, 3);
      end else begin
        mem_ack = busy ? 1'b0 : ($urandom_range(0, 3) == 0);
        mem_rdata = DW'($urandom);
        if (busy) wait_cnt++;
      end
      if (exp_i || !i_req) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = AW'($urandom) & ~AW'(3);
      end
      if (exp_d || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom) & ~AW'(3);
        d_wdata = DW'($urandom);
      end
      free_prev = cur_idle;
      ack_obs_prev = exp_i || exp_d;
      ack_given_prev = ack_given;
    end
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    repeat (3) tick;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_slow_memory;
    test_store;
    test_timeout;
    test_contention;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
